// File: rtl/sram_2p_march_bist_ctrl_if.sv
// Port bundle between the March C- BIST controller and one port of the 512x8
// two-port SRAM macro: BIST drive, read-back data and run status.
interface sram_2p_march_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  START;
  logic                  BIST_EN;
  logic                  BIST_MEN;
  logic                  BIST_WEN;
  logic                  BIST_REN;
  logic [ADDR_WIDTH-1:0] BIST_ADDR;
  logic [DATA_WIDTH-1:0] BIST_DIN;
  logic [DATA_WIDTH-1:0] BIST_BM;
  logic [DATA_WIDTH-1:0] BIST_DOUT;
  logic                  BUSY;
  logic                  DONE;
  logic                  FAIL;
  logic [ADDR_WIDTH-1:0] FAIL_ADDR;
  logic [CNT_WIDTH-1:0]  FAIL_CNT;

  modport master (
    input  START, BIST_DOUT,
    output BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM,
    output BUSY, DONE, FAIL, FAIL_ADDR, FAIL_CNT
  );

  modport slave (
    output START, BIST_DOUT,
    input  BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM,
    input  BUSY, DONE, FAIL, FAIL_ADDR, FAIL_CNT
  );
endinterface

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST controller for one SRAM port: sequences w0/r0w1/r1w0/r0w1/r1w0/r0,
// compares read data two edges after each read and keeps pass/fail statistics.
module sram_2p_march_bist_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  sram_2p_march_bist_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  en_q, en_d;
  logic                  men_q, men_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] bm_q, bm_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_exp_q, s1_exp_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;

  logic start_ok;
  logic in_march;
  logic is_read;
  logic wr_one;
  logic rd_one;
  logic mismatch;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.START;

    // phase_q=0 is the read half of a two-op element; the address moves after the write
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d = S_M0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_M0: begin
        if (addr_q == ADDR_TOP) begin
          state_d = S_M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_M1, S_M2: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == ADDR_TOP) begin
            state_d = (state_q == S_M1) ? S_M2 : S_M3;
            addr_d  = (state_q == S_M1) ? '0 : ADDR_TOP;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_M3, S_M4: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == '0) begin
            state_d = (state_q == S_M3) ? S_M4 : S_M5;
            addr_d  = (state_q == S_M3) ? ADDR_TOP : '0;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
      S_M5: begin
        if (addr_q == ADDR_TOP) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    in_march = state_d inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
    is_read  = (state_d == S_M5) ||
               ((state_d inside {S_M1, S_M2, S_M3, S_M4}) && !phase_d);
    wr_one   = (state_d == S_M1) || (state_d == S_M3);
    rd_one   = (state_d == S_M2) || (state_d == S_M4);

    busy_d = in_march || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    en_d   = busy_d;
    bm_d   = busy_d ? '1 : '0;
    men_d  = in_march;
    ren_d  = in_march && is_read;
    wen_d  = in_march && !is_read;
    din_d  = (wen_d && wr_one) ? '1 : '0;
    exp_d  = rd_one ? '1 : '0;

    // Read issued last cycle: the macro returns its data on this edge, compared on the next
    s1_valid_d = ren_q;
    s1_exp_d   = exp_q;
    s1_addr_d  = addr_q;
    mismatch   = s1_valid_q && (bus.BIST_DOUT != s1_exp_q);

    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_cnt_d  = fail_cnt_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_cnt_d  = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = s1_addr_q;
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      din_q       <= '0;
      bm_q        <= '0;
      exp_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_exp_q    <= '0;
      s1_addr_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      exp_q       <= exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_exp_q    <= s1_exp_d;
      s1_addr_q   <= s1_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign bus.BIST_EN   = en_q;
  assign bus.BIST_MEN  = men_q;
  assign bus.BIST_WEN  = wen_q;
  assign bus.BIST_REN  = ren_q;
  assign bus.BIST_ADDR = addr_q;
  assign bus.BIST_DIN  = din_q;
  assign bus.BIST_BM   = bm_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.FAIL      = fail_q;
  assign bus.FAIL_ADDR = fail_addr_q;
  assign bus.FAIL_CNT  = fail_cnt_q;

endmodule
